mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single data-memory port between the instruction-fetch requester and the MEM-stage requester of the 5-stage core. Each requester makes a level request with a registered one-cycle acknowledge, and the backing RAM may take a variable number of cycles. Conflicts are resolved by a small FSM, with a wait-state watchdog that aborts hung accesses. It sits between the IF/MEM stages, which derive their stalls as `req & ~ack`, and the memory subsystem.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 15, ram_ready-free BUSY cycles before abort (1..255)

Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch read request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetch read data, valid with `if_ack`
- `if_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid with `d_ack`
- `d_ack`  out  1  one-cycle completion pulse
- `err`  out  1  pulses with an ack when that access timed out
- `ram_req`  out  1  access active; held until `ram_ready` or abort
- `ram_we`  out  1  write strobe qualifier
- `ram_addr`  out  ADDR_W  latched address
- `ram_wdata`  out  DATA_W  latched store data
- `ram_rdata`  in  DATA_W  RAM read data, valid when `ram_ready`
- `ram_ready`  in  1  one-cycle access-complete from RAM

## Operation
- FSM states: `IDLE`, `BUSY_I`, `BUSY_D`. All outputs are registered.
- `IDLE`: candidates are the `if_req` and `d_req` lines, each masked in the cycle its own ack is high.
  - On a grant, latch addr, we and wdata into the `ram_*` registers, set `ram_req`, clear the wait counter, and go to `BUSY_I` or `BUSY_D`.
  - Fetch grants force `ram_we=0`.
- Priority, default: data beats fetch, because the MEM stage holds the older instruction.
- `BUSY_x` with `ram_ready=1`:
  - Drop `ram_req` and return to `IDLE`.
  - Pulse the owner's ack next cycle.
  - For a read, register `ram_rdata` into the owner's rdata.
  - For a write, rdata is unchanged.
- `BUSY_x` without `ram_ready`: the counter increments. When the counter equals `MAX_WAIT`, abort:
  - drop `ram_req` and return to `IDLE`;
  - ack the owner with `err=1`;
  - read data = 0.
- Same-cycle `ram_ready` and timeout: `ram_ready` wins and `err` stays 0.
- `ram_ready` while in `IDLE` is ignored.
- Requester inputs may change freely during `BUSY`; the latched values are used.
- Arithmetic: the counter is 8 bits and saturates. Compare as unsigned equality against `MAX_WAIT`.

## Timing
- Reset values: state `IDLE`; all outputs 0, including `ram_req`, acks, `err`, rdata and the `ram_*` buses. Reset clears `ram_req` immediately (asynchronously).
- Reset mid-access: the access is dropped with no ack. The requester must re-request after reset.
- Cycle flow for a request seen in cycle 0 while `IDLE`:
  - `ram_req=1` from cycle 1;
  - `ram_ready` arrives in cycle k≥1;
  - ack and data in cycle k+1;
  - a new grant is possible in cycle k+1, with `ram_req` again in k+2.
- Zero-wait RAM sustains one access per 2 cycles. `ram_req` has at least one low cycle between accesses.
- Timeout: with no `ram_ready`, the ack with `err` lands in cycle `MAX_WAIT`+2.
- Acks are exactly one cycle, never both in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A `last_grant` bit is updated on every grant.
  - When both requests are present, grant the requester not granted last.
  - Reset value of `last_grant` = data, so fetch wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed data-over-fetch priority and no `last_grant` register.
  - Fetch can starve only under continuous `d_req`, which the pipeline never produces.

## Test plan
- Single fetch, `if_addr`=0x100, RAM returns 0xDEADBEEF at k=3 -> `ram_req` high in cycles 1-3, `if_ack` and `if_rdata`=0xDEADBEEF in cycle 4, `err`=0.
- Store, `d_addr`=0x2000, `d_wdata`=0x12345678, zero-wait RAM -> `ram_we`=1 with the latched values in cycle 1, `d_ack` in cycle 2, `d_rdata` unchanged.
- Both requests in cycle 0, zero-wait RAM:
  - undefined macro -> data served first (`d_ack` cycle 2), fetch second (`if_ack` cycle 4);
  - with `MEM_ARB_RR_EN` -> fetch first, and the next tie goes to data.
- `ram_ready` never asserted, `MAX_WAIT`=15 -> `ram_req` drops, and `d_ack`=1, `err`=1, `d_rdata`=0 in cycle 17; a `ram_ready` landing in the timeout cycle instead gives a normal ack with `err`=0.
- `rst` asserted mid-`BUSY_D` -> `ram_req`=0 asynchronously, no ack; after release, a fresh `d_req` is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between instruction fetch and the MEM stage.
// Latency: request seen in IDLE -> ram_req next cycle; ack one cycle after ram_ready.
// Backpressure: requesters hold req until their one-cycle ack; MAX_WAIT aborts hung accesses.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration (default: data beats fetch).
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t              state_q, state_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_cand, d_cand, gnt_i, gnt_d;

  // A requester is not a candidate in the cycle its own ack is showing.
  assign if_cand = if_req & ~if_ack_q;
  assign d_cand  = d_req & ~d_ack_q;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1 = data was granted last

  // Tie goes to whoever was not granted last; otherwise the lone requester wins.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (if_cand && d_cand) begin
      gnt_d = ~last_grant_q;
      gnt_i = last_grant_q;
    end else begin
      gnt_i = if_cand;
      gnt_d = d_cand;
    end
  end

  // Remember the owner of every grant taken from IDLE.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && gnt_d)      last_grant_d = 1'b1;
    else if (state_q == IDLE && gnt_i) last_grant_d = 1'b0;
  end

  // last_grant resets to data so fetch takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: the MEM stage holds the older instruction.
  always_comb begin
    gnt_d = d_cand;
    gnt_i = if_cand & ~d_cand;
  end
`endif

  // Next-state and registered-output computation for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cnt_d       = cnt_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d     = BUSY_D;
          ram_req_d   = 1'b1;
          ram_we_d    = d_we;
          ram_addr_d  = d_addr;
          ram_wdata_d = d_wdata;
          cnt_d       = 8'd0;
        end else if (gnt_i) begin
          state_d     = BUSY_I;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr;
          cnt_d       = 8'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (ram_ready) begin
          // Completion beats a same-cycle timeout.
          state_d   = IDLE;
          ram_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_ack_d = 1'b1;
            if (!ram_we_q) d_rdata_d = ram_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_rdata;
          end
        end else if (cnt_q == MAX_WAIT_C) begin
          state_d   = IDLE;
          ram_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any access in flight without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cnt_q       <= 8'd0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cnt_q       <= cnt_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load, store, conflict, timeout, reset.
// Cycle 0 is the cycle in which a request is first driven; outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_ram_req", ram_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_err", err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    step();

    // ---------------- single fetch, ready at k=3 ----------------
    if_req = 1'b1; if_addr = 32'h100;                      // cycle 0
    step();                                                 // cycle 1
    chk("f_c1_ram_req", ram_req, 1);
    chk("f_c1_ram_we", ram_we, 0);
    chk("f_c1_ram_addr", ram_addr, 32'h100);
    if_addr = 32'hFFF;                                      // latched address must hold
    step();                                                 // cycle 2
    chk("f_c2_ram_req", ram_req, 1);
    chk("f_c2_ram_addr", ram_addr, 32'h100);
    step();                                                 // cycle 3
    chk("f_c3_ram_req", ram_req, 1);
    chk("f_c3_if_ack", if_ack, 0);
    ram_ready = 1'b1; ram_rdata = 32'hDEADBEEF;
    step();                                                 // cycle 4
    ram_ready = 1'b0; ram_rdata = 32'h0;
    chk("f_c4_if_ack", if_ack, 1);
    chk("f_c4_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_c4_err", err, 0);
    chk("f_c4_d_ack", d_ack, 0);
    chk("f_c4_ram_req", ram_req, 0);
    if_req = 1'b0;
    step();                                                 // cycle 5
    chk("f_c5_if_ack", if_ack, 0);
    chk("f_c5_ram_req", ram_req, 0);

    // ---------------- data load, zero wait ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step();
    chk("ld_c1_ram_addr", ram_addr, 32'h40);
    chk("ld_c1_ram_we", ram_we, 0);
    ram_ready = 1'b1; ram_rdata = 32'hCAFEF00D;
    step();
    ram_ready = 1'b0;
    chk("ld_c2_d_ack", d_ack, 1);
    chk("ld_c2_d_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 1'b0;
    step();

    // ---------------- store, zero wait ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678;
    step();                                                 // cycle 1
    chk("st_c1_ram_req", ram_req, 1);
    chk("st_c1_ram_we", ram_we, 1);
    chk("st_c1_ram_addr", ram_addr, 32'h2000);
    chk("st_c1_ram_wdata", ram_wdata, 32'h12345678);
    ram_ready = 1'b1; ram_rdata = 32'h99999999;
    step();                                                 // cycle 2
    ram_ready = 1'b0;
    chk("st_c2_d_ack", d_ack, 1);
    chk("st_c2_d_rdata_kept", d_rdata, 32'hCAFEF00D);
    chk("st_c2_err", err, 0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    chk("st_c3_d_ack", d_ack, 0);

    // ---------------- both requests in cycle 0 ----------------
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_addr = 32'h400;                         // cycle 0
    step();                                                 // cycle 1
`ifdef MEM_ARB_RR_EN
    chk("tie_c1_ram_addr", ram_addr, 32'h300);
`else
    chk("tie_c1_ram_addr", ram_addr, 32'h400);
`endif
    ram_ready = 1'b1; ram_rdata = 32'h11111111;
    step();                                                 // cycle 2
    ram_ready = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("tie_c2_if_ack", if_ack, 1);
    chk("tie_c2_d_ack", d_ack, 0);
    chk("tie_c2_if_rdata", if_rdata, 32'h11111111);
    if_req = 1'b0;
`else
    chk("tie_c2_d_ack", d_ack, 1);
    chk("tie_c2_if_ack", if_ack, 0);
    chk("tie_c2_d_rdata", d_rdata, 32'h11111111);
    d_req = 1'b0;
`endif
    step();                                                 // cycle 3
    chk("tie_c3_ram_req", ram_req, 1);
`ifdef MEM_ARB_RR_EN
    chk("tie_c3_ram_addr", ram_addr, 32'h400);
`else
    chk("tie_c3_ram_addr", ram_addr, 32'h300);
`endif
    ram_ready = 1'b1; ram_rdata = 32'h22222222;
    step();                                                 // cycle 4
    ram_ready = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("tie_c4_d_ack", d_ack, 1);
    chk("tie_c4_if_ack", if_ack, 0);
    chk("tie_c4_d_rdata", d_rdata, 32'h22222222);
`else
    chk("tie_c4_if_ack", if_ack, 1);
    chk("tie_c4_d_ack", d_ack, 0);
    chk("tie_c4_if_rdata", if_rdata, 32'h22222222);
`endif
    if_req = 1'b0; d_req = 1'b0;
    step();

    // ---------------- timeout, ram_ready never comes ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;           // cycle 0
    for (int c = 1; c <= 16; c++) begin
      step();                                               // cycles 1..16
      chk("to_busy_ram_req", ram_req, 1);
      chk("to_busy_d_ack", d_ack, 0);
    end
    step();                                                 // cycle 17
    chk("to_c17_d_ack", d_ack, 1);
    chk("to_c17_err", err, 1);
    chk("to_c17_d_rdata", d_rdata, 0);
    chk("to_c17_ram_req", ram_req, 0);
    d_req = 1'b0;
    step();                                                 // cycle 18
    chk("to_c18_err", err, 0);
    chk("to_c18_d_ack", d_ack, 0);

    // ---------------- ram_ready in the timeout cycle ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;           // cycle 0
    for (int c = 1; c <= 16; c++) step();                   // reach cycle 16
    ram_ready = 1'b1; ram_rdata = 32'h55AA55AA;
    step();                                                 // cycle 17
    ram_ready = 1'b0;
    chk("race_d_ack", d_ack, 1);
    chk("race_err", err, 0);
    chk("race_d_rdata", d_rdata, 32'h55AA55AA);
    d_req = 1'b0;
    step();

    // ---------------- ram_ready while idle is ignored ----------------
    ram_ready = 1'b1; ram_rdata = 32'h77777777;
    step();
    ram_ready = 1'b0;
    chk("idle_rdy_d_ack", d_ack, 0);
    chk("idle_rdy_if_ack", if_ack, 0);
    chk("idle_rdy_ram_req", ram_req, 0);
    chk("idle_rdy_d_rdata", d_rdata, 32'h55AA55AA);

    // ---------------- reset in the middle of BUSY_D ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'hA5A5A5A5;
    step();                                                 // cycle 1
    chk("rb_c1_ram_req", ram_req, 1);
    step();                                                 // cycle 2
    #2 rst = 1'b1;
    #1;
    chk("rb_async_ram_req", ram_req, 0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    chk("rb_no_d_ack", d_ack, 0);
    chk("rb_err", err, 0);
    rst = 1'b0;
    step();
    chk("rb_post_ram_req", ram_req, 0);
    d_req = 1'b1; d_addr = 32'h800;                         // fresh request, cycle 0
    step();                                                 // cycle 1
    chk("rb_new_ram_req", ram_req, 1);
    chk("rb_new_ram_addr", ram_addr, 32'h800);
    ram_ready = 1'b1; ram_rdata = 32'h0BADF00D;
    step();                                                 // cycle 2
    ram_ready = 1'b0;
    chk("rb_new_d_ack", d_ack, 1);
    chk("rb_new_d_rdata", d_rdata, 32'h0BADF00D);
    d_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
